// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-input stream arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    // Arbitration decision taken from IDLE; on contention the requester
    // that did not hold the previous grant wins.
    function automatic arb_state_t arb_pick(input logic v0, input logic v1,
                                            input logic last_grant);
        arb_state_t pick;
        pick = ARB_IDLE;
        if (v0 && v1) begin
            pick = (last_grant == SEL_IN1) ? ARB_GRANT0 : ARB_GRANT1;
        end else if (v0) begin
            pick = ARB_GRANT0;
        end else if (v1) begin
            pick = ARB_GRANT1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux2_stream_arbiter_mux.sv
// Single-bit 2:1 mux primitive; y follows a1 when s is high, else a0.
module mux2_stream_arbiter_mux (
    input  logic a0,
    input  logic a1,
    input  logic s,
    output logic y
);

    assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin packet arbiter sharing a 2:1 payload mux with one registered output stage.
// Optional per-grant beat limit is enabled by defining ARB_BURST_LIMIT_EN.
module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int PW = DATA_W + 1;

    generate
        if (MAX_BURST < 1) begin : g_bad_burst
            $error("MAX_BURST must be at least 1");
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic [PW-1:0]     mux_a0, mux_a1, mux_y;
    logic              xfer;
    logic              beat_last;
    logic              burst_done;
    logic              release_grant;

    // Payload and last flag share the same per-bit mux column.
    assign mux_a0 = {in0_last, in0_data};
    assign mux_a1 = {in1_last, in1_data};

    generate
        for (genvar i = 0; i < PW; i++) begin : g_mux
            mux2_stream_arbiter_mux u_mux (
                .a0 (mux_a0[i]),
                .a1 (mux_a1[i]),
                .s  (sel),
                .y  (mux_y[i])
            );
        end
    endgenerate

    assign beat_last     = mux_y[DATA_W];
    assign xfer          = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    assign release_grant = xfer & (beat_last | burst_done);

`ifdef ARB_BURST_LIMIT_EN
    localparam int                CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_FINAL = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == ARB_IDLE) begin
            beat_cnt_d = '0;
        end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // The beat now transferring is the last one this grant may carry.
    assign burst_done = (beat_cnt_q == BURST_FINAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SEL_IN1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                state_d = arb_pick(in0_valid, in1_valid, last_grant_q);
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (release_grant) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = sel;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Ready is masked during reset so no beat is taken in a reset cycle.
    always_comb begin
        sel       = SEL_IN0;
        busy      = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state_q)
            ARB_GRANT0: begin
                busy      = 1'b1;
                in0_ready = ~rst & (out_ready | ~out_valid_q);
            end
            ARB_GRANT1: begin
                sel       = SEL_IN1;
                busy      = 1'b1;
                in1_ready = ~rst & (out_ready | ~out_valid_q);
            end
            default: begin
                sel = SEL_IN0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y[DATA_W-1:0];
            out_last_d  = beat_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 datapath mux between two valid/ready packet streams.
- Drives the mux select and locks the grant for a whole packet, ending at the beat with last=1.
- Its single registered output stage feeds a downstream valid/ready consumer.
- Sits directly in front of the 2:1 mux primitive wherever two producers share one link.

Parameters:
- DATA_W, 8, payload width per beat.
- MAX_BURST, 4, beat limit per grant. Used only when ARB_BURST_LIMIT_EN is defined; must be ≥1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DATA_W  requester 0 payload.
- in0_last  input  1  requester 0 final beat of packet.
- in0_ready  output  1  requester 0 beat accepted this cycle.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  DATA_W  requester 1 payload.
- in1_last  input  1  requester 1 final beat of packet.
- in1_ready  output  1  requester 1 beat accepted this cycle.
- out_valid  output  1  registered beat available.
- out_data  output  DATA_W  registered payload.
- out_last  output  1  registered last flag.
- out_ready  input  1  consumer accepts the out beat.
- sel  output  1  mux select; 0 = in0, 1 = in1. Valid while busy.
- busy  output  1  grant currently held.

Behaviour:
- Reset values (synchronous; rst dominates every other event):
  - state=IDLE, sel=0, busy=0, out_valid=0, out_data=0, out_last=0, in0_ready=in1_ready=0.
  - last_grant=1, so in0 wins the first contention.
- Reset mid-packet: the partial packet is dropped, any held output beat is discarded, and no further beats issue until re-arbitration.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - in_ready both 0.
  - If only inN_valid is high, go to GRANTN.
  - If both are high, grant the index != last_grant.
  - Otherwise stay in IDLE.
  - Grant takes effect next cycle (1-cycle arbitration latency). sel and busy update with the state register.
- GRANTn:
  - sel=n, busy=1.
  - in_ready[n] = out_ready | ~out_valid. The non-granted in_ready is always 0.
- Transfer: in_valid[n] & in_ready[n]. This loads out_data/out_last from the mux output and sets out_valid=1.
- Output drain: out_valid & out_ready with no new transfer clears out_valid. A simultaneous drain and load keeps out_valid=1 with the new beat (full throughput, 1 beat/cycle).
- Output stall: out_valid & ~out_ready holds out_data/out_last stable, and in_ready[n] drops the same cycle.
- Packet end: a transfer with last=1 sets last_grant=n and moves to IDLE next cycle. This gives one idle bubble between packets.
- Fairness: under continuous demand from both requesters, grants alternate per packet.
- A single-beat packet (valid with last=1) is legal.
- Granted requester deasserting valid mid-packet: the grant is held and the state waits indefinitely.
- Requester-side valid/data must remain stable until ready; the arbiter does not check this.
- Total latency: request → first out_valid = 2 cycles (arbitrate, then register).

Optional Feature:
- Macro ARB_BURST_LIMIT_EN.
- Defined:
  - A beat counter (width $clog2(MAX_BURST+1)) resets to 0 on each grant and increments per transfer.
  - When the count reaches MAX_BURST without last, the grant is released and last_grant updated exactly as at packet end.
  - The remaining beats re-arbitrate as a continuation.
  - This is for latency-bounded links only; packets may interleave beat-groups.
- Undefined: no counter logic; the grant is held strictly until last=1.

Decomposition:
- Package mux2_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1}.
  - Localparam constants SEL_IN0=1'b0, SEL_IN1=1'b1.
- Sub-module:
  - The payload path instantiates the existing 2:1 mux primitive per bit (generate loop) driven by sel.
  - The arbiter FSM stays in the top module; no further sub-module.

Test Plan:
- Reset and first grant: rst high for 2 cycles, then in0_valid=in1_valid=1 with 1-beat packets → all outputs 0 during reset; first out_data=in0_data (0xA0) at cycle 2 after release, sel=0; next packet from in1 (0xB0), sel=1.
- Multi-beat lock: in0 sends 3 beats 0x11, 0x12, 0x13 (last on 0x13) while in1_valid=1 throughout → out sequence 0x11, 0x12, 0x13, then in1's 0x21 after one idle cycle. in1_ready stays 0 during in0's packet.
- Backpressure: out_ready=0 for 3 cycles mid-packet → out_data is held, in0_ready=0 and no beat is lost or duplicated; resuming out_ready=1 continues with the next beat.
- Reset mid-packet: assert rst after beat 2 of 4 → out_valid=0 next cycle, busy=0; after release with both valid, in0 is granted first.
- Alternation: both requesters send 10 consecutive 1-beat packets (in0 0x00–0x09, in1 0x80–0x89) → strict interleaving 0x00, 0x80, 0x01, 0x81 … and a scoreboard passes all 20 beats.
- ARB_BURST_LIMIT_EN with MAX_BURST=2: in0 sends a 5-beat packet and in1 sends a 1-beat packet → output order in0 b0, b1, in1, in0 b2, b3, then in0 b4.
